// File: rtl/prbs_ber_checker.sv
// PN5 receive checker: self-syncs a local x^5+x^3+1 generator,
// then counts checked bits and bit errors while locked.
module prbs_ber_checker #(
    parameter int SYNC_LEN    = 16,
    parameter int LOSS_THRESH = 4,
    parameter int LOSS_WIN    = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             sat
);

    localparam int RUN_W = $clog2(SYNC_LEN + 1);
    localparam int WIN_W = $clog2(LOSS_WIN);
    localparam int WE_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(SYNC_LEN - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(LOSS_WIN - 1);
    localparam logic [WE_W-1:0]  ERR_LIM  = WE_W'(LOSS_THRESH);

    typedef enum logic [1:0] {
        FILL,
        VERIFY,
        LOCKED
    } state_t;

    state_t           state;
    logic [4:0]       h;
    logic [2:0]       fill_cnt;
    logic [RUN_W-1:0] run;
    logic [WIN_W-1:0] win_cnt;
    logic [WE_W-1:0]  win_err;

    logic             pred;
    logic             mis;
    logic [WE_W-1:0]  win_err_nxt;
    logic [CNT_W-1:0] bit_nxt;
    logic [CNT_W-1:0] err_nxt;
    logic             sat_nxt;

    always_comb begin
        pred        = h[2] ^ h[4];
        mis         = in_bit ^ pred;
        win_err_nxt = win_err + WE_W'(mis);
        bit_nxt     = bit_cnt;
        err_nxt     = err_cnt;
        if (clr) begin
            bit_nxt = '0;
            err_nxt = '0;
        end else if (in_valid && state == LOCKED) begin
            if (bit_cnt != '1)
                bit_nxt = bit_cnt + 1'b1;
            if (mis && err_cnt != '1)
                err_nxt = err_cnt + 1'b1;
        end
        sat_nxt = !clr && (sat || (&bit_nxt) || (&err_nxt));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            h         <= '0;
            fill_cnt  <= '0;
            run       <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
            sat       <= 1'b0;
        end else begin
            bit_cnt   <= bit_nxt;
            err_cnt   <= err_nxt;
            sat       <= sat_nxt;
            err_pulse <= 1'b0;
            if (in_valid) begin
                unique case (state)
                    FILL: begin
                        h <= {h[3:0], in_bit};
                        if (fill_cnt == 3'd4) begin
                            fill_cnt <= '0;
                            state    <= VERIFY;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                    VERIFY: begin
                        h <= {h[3:0], in_bit};
                        if (mis) begin
                            run <= '0;
                        end else if (h != '0) begin
                            // all-zero history predicts zero forever; never lock on it
                            if (run == RUN_LAST) begin
                                run    <= '0;
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                run <= run + 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        // flywheel: a line error cannot corrupt the history
                        h         <= {h[3:0], pred};
                        err_pulse <= mis;
                        if (win_err_nxt == ERR_LIM) begin
                            state    <= FILL;
                            locked   <= 1'b0;
                            fill_cnt <= '0;
                            run      <= '0;
                            win_cnt  <= '0;
                            win_err  <= '0;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            win_err <= win_err_nxt;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule
